// File: rtl/rr_priority_encoder_8.sv
// Registered round-robin arbiter over 8 requesters with grant hold,
// ack/withdraw release and a bounded hold time.
module rr_priority_encoder_8 #(
  parameter int N       = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             valid_d, timeout_d;

  logic [IDX_W-1:0] base, win, k;
  logic             any_req;
  logic             rel, wdr, tmo;

  // In GRANT the search base is the pointer an exit would install.
  always_comb begin
    base    = (state_q == GRANT) ? idx + 1'b1 : ptr_q;
    any_req = |req;
    win     = '0;
    k       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = base + IDX_W'(i);
      if (req[k]) win = k;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx;
    valid_d   = valid;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    rel       = ack;
    wdr       = ~req[idx];
    tmo       = (cnt_q == CNT_LAST);
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          idx_d   = win;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel || wdr || tmo) begin
          ptr_d     = idx + 1'b1;
          timeout_d = ~rel & ~wdr;
          cnt_d     = '0;
          if (any_req) begin
            idx_d   = win;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx     <= idx_d;
      valid   <= valid_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder_8.sv
// Directed bench for rr_priority_encoder_8: vector table plus
// hand-written timeout, withdrawal and mid-grant reset sequences.
module tb_rr_priority_encoder_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       ack = 1'b0;
  logic [2:0] idx;
  logic       valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_priority_encoder_8 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .idx     (idx),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t tbl[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] e_idx,
                       input logic e_v, input logic e_t);
    checks++;
    if (idx !== e_idx || valid !== e_v || timeout !== e_t) begin
      errors++;
      $display("FAIL %s: got idx=%0d valid=%0b timeout=%0b, want idx=%0d valid=%0b timeout=%0b",
               name, idx, valid, timeout, e_idx, e_v, e_t);
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] q, input logic a);
    rst = r;
    req = q;
    ack = a;
    step();
  endtask

  initial begin
    // reset with all requests pending, then first grant
    tbl[0]  = '{1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0};
    // single request held three cycles
    tbl[4]  = '{1'b0, 8'h20, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h20, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h20, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 1'b0};
    // rotation from ptr=0 with continuous ack
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'hFF, 1'b1, 3'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'hFF, 1'b1, 3'd2, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'hFF, 1'b1, 3'd3, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'hFF, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'hFF, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'hFF, 1'b1, 3'd6, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 8'hFF, 1'b1, 3'd7, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0};
    // pointer wrap: 7 then 0
    tbl[19] = '{1'b0, 8'h81, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 8'h81, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].ack);
      check($sformatf("vec%0d", i), tbl[i].idx, tbl[i].valid, tbl[i].to);
    end

    // timeout: 15 grant cycles, pulse, no-gap re-grant
    apply(1'b0, 8'h04, 1'b0);
    check("to_grant", 3'd2, 1'b1, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      step();
      check($sformatf("to_hold%0d", i), 3'd2, 1'b1, 1'b0);
    end
    step();
    check("to_pulse", 3'd2, 1'b1, 1'b1);
    step();
    check("to_after", 3'd2, 1'b1, 1'b0);
    // drive to the last hold cycle, then ack must beat timeout
    for (int i = 0; i < 13; i++) step();
    check("to_last", 3'd2, 1'b1, 1'b0);
    apply(1'b0, 8'h00, 1'b1);
    check("ack_beats_to", 3'd2, 1'b0, 1'b0);

    // withdrawal
    apply(1'b0, 8'h08, 1'b0);
    check("wd_grant", 3'd3, 1'b1, 1'b0);
    apply(1'b0, 8'h00, 1'b0);
    check("wd_drop", 3'd3, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1);
    check("idle_hold", 3'd3, 1'b0, 1'b0);

    // mid-grant reset returns pointer to 0
    apply(1'b0, 8'h08, 1'b0);
    check("rst_grant", 3'd3, 1'b1, 1'b0);
    apply(1'b1, 8'h08, 1'b1);
    check("rst_mid", 3'd0, 1'b0, 1'b0);
    apply(1'b0, 8'h09, 1'b0);
    check("rst_regrant", 3'd0, 1'b1, 1'b0);
    apply(1'b0, 8'h09, 1'b1);
    check("rst_next", 3'd3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
